icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache. It answers the fetch-stage PC with an instruction word.
- On a hit the instruction is returned in the same cycle.
- On a miss it raises stall_o (the fetch stage drives the PC enable from ~stall_o) and refills a whole line from main memory over a req/gnt/rvalid interface.
- Sits between the PC register and the instruction-memory port.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_refill_fsm.sv | 90 +++++++++
 rtl/icache_direct.sv | 99 +++++++++
 tb/tb_icache_direct.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int data_width, input int num_sets, input int line_words);
        return data_width - off_bits(line_words) - idx_bits(num_sets);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss handling for icache_direct: latches the miss line, runs the memory
// req/gnt handshake and streams refill beats into the cache arrays.
//
//   state | meaning
//   IDLE  | lookups active; a miss latches the line address
//   REQ   | mem_req held with the miss address until mem_gnt
//   FILL  | each mem_rvalid writes one word; last word installs tag and valid
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int LINE_WORDS = 4,
    localparam int OFF   = off_bits(LINE_WORDS),
    localparam int IDX   = idx_bits(NUM_SETS),
    localparam int TAGW  = tag_bits(DATA_WIDTH, NUM_SETS, LINE_WORDS),
    localparam int WORDW = $clog2(LINE_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss,
    input  logic [DATA_WIDTH-OFF-1:0] line,
    input  logic                      flush,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      idle,
    output logic                      fill_we,
    output logic                      fill_done,
    output logic [IDX-1:0]            fill_index,
    output logic [WORDW-1:0]          fill_word,
    output logic [DATA_WIDTH-1:0]     fill_data,
    output logic [TAGW-1:0]           fill_tag,
    output logic                      inval_all,
    output logic                      mem_req,
    output logic [DATA_WIDTH-1:0]     mem_addr
);

    state_t                  state, state_next;
    logic [WORDW-1:0]        beat;
    logic [DATA_WIDTH-1:0]   miss_addr;
    logic                    flush_pending;
    logic                    last_beat;

    assign last_beat = (beat == WORDW'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            miss_addr     <= '0;
            flush_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && miss)
                miss_addr <= {line, {OFF{1'b0}}};
            if (state == REQ && mem_gnt)
                beat <= '0;
            else if (state == FILL && mem_rvalid)
                beat <= beat + WORDW'(1);
            // A flush seen mid-refill is replayed on the first IDLE edge.
            if (state == IDLE)
                flush_pending <= 1'b0;
            else if (flush)
                flush_pending <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss) state_next = REQ;
            REQ:     if (mem_gnt) state_next = FILL;
            FILL:    if (mem_rvalid && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign idle       = (state == IDLE);
    assign mem_req    = (state == REQ);
    assign mem_addr   = miss_addr;
    assign fill_we    = (state == FILL) && mem_rvalid;
    assign fill_done  = fill_we && last_beat;
    assign fill_index = miss_addr[OFF+IDX-1:OFF];
    assign fill_word  = beat;
    assign fill_data  = mem_rdata;
    assign fill_tag   = miss_addr[DATA_WIDTH-1:OFF+IDX];
    assign inval_all  = idle && (flush || flush_pending);

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stall and
// whole-line refill over a req/gnt/rvalid memory port on a miss.
module icache_direct
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int OFF   = off_bits(LINE_WORDS);
    localparam int IDX   = idx_bits(NUM_SETS);
    localparam int TAGW  = tag_bits(DATA_WIDTH, NUM_SETS, LINE_WORDS);
    localparam int WORDW = $clog2(LINE_WORDS);

    logic [NUM_SETS-1:0]   valid;
    logic [TAGW-1:0]       tags [NUM_SETS];
    logic [DATA_WIDTH-1:0] data [NUM_SETS][LINE_WORDS];

    logic [WORDW-1:0]      word;
    logic [IDX-1:0]        index;
    logic [TAGW-1:0]       tag;
    logic                  idle, hit, miss;
    logic                  fill_we, fill_done, inval_all;
    logic [IDX-1:0]        fill_index;
    logic [WORDW-1:0]      fill_word;
    logic [DATA_WIDTH-1:0] fill_data;
    logic [TAGW-1:0]       fill_tag;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^pc_i[1:0];

    assign word  = pc_i[OFF-1:2];
    assign index = pc_i[OFF+IDX-1:OFF];
    assign tag   = pc_i[DATA_WIDTH-1:OFF+IDX];

    assign hit     = req_i && idle && valid[index] && (tags[index] == tag);
    assign miss    = req_i && idle && !hit;
    assign stall_o = (req_i && !hit) || !idle;
    assign instr_o = data[index][word];

    icache_refill_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .miss       (miss),
        .line       (pc_i[DATA_WIDTH-1:OFF]),
        .flush      (flush_i),
        .mem_gnt    (mem_gnt_i),
        .mem_rvalid (mem_rvalid_i),
        .mem_rdata  (mem_rdata_i),
        .idle       (idle),
        .fill_we    (fill_we),
        .fill_done  (fill_done),
        .fill_index (fill_index),
        .fill_word  (fill_word),
        .fill_data  (fill_data),
        .fill_tag   (fill_tag),
        .inval_all  (inval_all),
        .mem_req    (mem_req_o),
        .mem_addr   (mem_addr_o)
    );

    // Invalidate-all and line install never coincide: one is IDLE-only, the other FILL-only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (inval_all)
                valid <= '0;
            if (fill_done)
                valid[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we)
            data[fill_index][fill_word] <= fill_data;
        if (fill_done)
            tags[fill_index] <= fill_tag;
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: table-driven fetches scored against a
// queue of expected words/stall counts, plus flush and reset corner sequences.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] instr_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    icache_direct dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .instr_o      (instr_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Backing memory contents: two fixed lines, everything else address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] line;
        line = {a[31:4], 4'b0};
        if (line == 32'hBFC0_0000) return 32'h11 * (32'(a[3:2]) + 32'd1);
        if (line == 32'hBFC0_0400) return 32'hA0 + 32'(a[3:2]);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model
    int          gnt_delay = 0;
    logic        gap_en = 1'b0;
    int          wait_cnt = 0;
    int          beats_left = 0;
    logic        gap_phase = 1'b0;
    logic [31:0] cur_line = '0;
    logic [31:0] exp_maddr = '0;
    int          grants = 0;

    always @(negedge clk) begin
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        if (rst) begin
            beats_left = 0;
            wait_cnt = 0;
            gap_phase = 1'b0;
        end else if (beats_left > 0) begin
            if (gap_en && gap_phase) begin
                gap_phase = 1'b0;
            end else begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = mem_word(cur_line + 32'(4 * (4 - beats_left)));
                beats_left--;
                gap_phase = gap_en;
            end
        end else if (mem_req_o) begin
            check("mem_addr", mem_addr_o, exp_maddr);
            if (wait_cnt == gnt_delay) begin
                mem_gnt_i = 1'b1;
                cur_line = mem_addr_o;
                beats_left = 4;
                wait_cnt = 0;
                gap_phase = 1'b0;
                grants++;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Scoreboard: one entry per fetch, retired when the DUT delivers without stall.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    int   delivered = 0;
    int   run = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run = 0;
        end else if (req_i) begin
            if (stall_o) begin
                run++;
            end else if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_delivery: pc %08h instr %08h", pc_i, instr_o);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("instr@%08h", e.pc), instr_o, e.instr);
                check($sformatf("stalls@%08h", e.pc), 32'(run), 32'(e.stalls));
                delivered++;
                run = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after delivery.
    task automatic fetch(input logic [31:0] pc, input logic fl, input logic [31:0] instr, input int stalls);
        int target;
        int g0;
        sb_q.push_back('{pc, instr, stalls});
        exp_maddr = {pc[31:4], 4'b0};
        g0 = grants;
        target = delivered + 1;
        req_i = 1'b1;
        pc_i = pc;
        if (fl) flush_i = 1'b1;
        for (int c = 0; c < 100 && delivered < target; c++) begin
            @(posedge clk);
            #1;
            if (fl) flush_i = 1'b0;
        end
        if (delivered < target) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout@%08h: no delivery within 100 cycles", pc);
            void'(sb_q.pop_back());
        end else begin
            check($sformatf("grants@%08h", pc), 32'(grants - g0), (stalls > 0) ? 32'd1 : 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          stalls;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'hBFC0_0000, 32'h11, 6};
        vecs[1] = '{32'hBFC0_0004, 32'h22, 0};
        vecs[2] = '{32'hBFC0_0008, 32'h33, 0};
        vecs[3] = '{32'hBFC0_000C, 32'h44, 0};
        vecs[4] = '{32'hBFC0_0400, 32'hA0, 6};
        vecs[5] = '{32'hBFC0_040C, 32'hA3, 0};
        vecs[6] = '{32'hBFC0_0000, 32'h11, 6};
        vecs[7] = '{32'hBFC0_0008, 32'h33, 0};

        #2;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, same-line hits, conflict eviction and the return miss
        foreach (vecs[i])
            fetch(vecs[i].pc, 1'b0, vecs[i].instr, vecs[i].stalls);

        // Slow memory: 3-cycle grant, gaps between beats
        gnt_delay = 3;
        gap_en = 1'b1;
        fetch(32'h0000_1230, 1'b0, mem_word(32'h0000_1230), 12);
        fetch(32'h0000_1234, 1'b0, mem_word(32'h0000_1234), 0);
        fetch(32'h0000_1238, 1'b0, mem_word(32'h0000_1238), 0);
        fetch(32'h0000_123C, 1'b0, mem_word(32'h0000_123C), 0);
        gnt_delay = 0;
        gap_en = 1'b0;

        // Flush during FILL: the line still delivers once, then misses again
        fork
            fetch(32'hBFC0_0010, 1'b0, mem_word(32'hBFC0_0010), 6);
            begin
                for (int c = 0; c < 50 && !mem_rvalid_i; c++) @(negedge clk);
                @(posedge clk);
                #1 flush_i = 1'b1;
                @(posedge clk);
                #1 flush_i = 1'b0;
            end
        join
        fetch(32'hBFC0_0010, 1'b0, mem_word(32'hBFC0_0010), 6);
        fetch(32'hBFC0_0000, 1'b0, 32'h11, 6);

        // Flush in IDLE on a hit: this fetch hits, the next one misses
        fetch(32'hBFC0_0004, 1'b1, 32'h22, 0);
        fetch(32'hBFC0_0004, 1'b0, 32'h22, 6);

        // Reset while in REQ: mem_req_o must fall without a clock edge
        gnt_delay = 5;
        exp_maddr = 32'h0000_3000;
        req_i = 1'b1;
        pc_i = 32'h0000_3000;
        for (int c = 0; c < 20 && !mem_req_o; c++) @(negedge clk);
        check("req_before_rst", 32'(mem_req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("req_rst_mem_req", 32'(mem_req_o), 32'd0);
        check("req_rst_mem_addr", mem_addr_o, 32'd0);
        req_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        gnt_delay = 0;
        @(posedge clk);
        #1;
        fetch(32'h0000_3000, 1'b0, mem_word(32'h0000_3000), 6);

        // Reset mid-FILL after two beats; no beats issued after reset
        exp_maddr = 32'h0000_2000;
        pc_i = 32'h0000_2000;
        req_i = 1'b1;
        for (int c = 0; c < 20 && beats_left != 2; c++) @(negedge clk);
        check("fill_two_beats", 32'(beats_left), 32'd2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("fill_rst_mem_req", 32'(mem_req_o), 32'd0);
        check("fill_rst_stall", 32'(stall_o), 32'd1);
        req_i = 1'b0;
        #1;
        check("rst_idle_nostall", 32'(stall_o), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_noreq_stall", 32'(stall_o), 32'd0);
        fetch(32'h0000_2000, 1'b0, mem_word(32'h0000_2000), 6);
        fetch(32'h0000_2008, 1'b0, mem_word(32'h0000_2008), 0);
        fetch(32'h0000_1234, 1'b0, mem_word(32'h0000_1234), 6);

        req_i = 1'b0;
        @(negedge clk);
        check("final_noreq_stall", 32'(stall_o), 32'd0);
        check("final_mem_req", 32'(mem_req_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
